repeat_signal_generator: RTL and testbench
==========================================

Name: repeat_signal_generator

Overview:
Sparse-pipeline primitive that turns a coordinate stream into a repeat-signal stream.
- Each data (coordinate) token becomes one repeat token "R".
- Stop and done tokens are forwarded with the configured level offset applied to stop tokens only.
- Sits between a coordinate source (scanner/GLB writer) and a repeater.
- Both sides use 17-bit valid/ready streams.

Parameters:
- FIFO_DEPTH, 2, depth of the input FIFO and of the output FIFO (power of 2, >=2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clk_en  input  1  when 0, all state holds (no push, pop or state change).
- flush  input  1  synchronous clear of FIFOs and FSM; has priority over traffic.
- tile_en  input  1  block enable; when 0 the block is inert.
- stop_lvl  input  16  stop-level offset config; bits[7:0] used, quasi-static.
- base_data_in  input  17  input token.
- base_data_in_valid  input  1  input token valid.
- base_data_in_ready  output  1  input FIFO not full, tile_en=1 and rst_n deasserted.
- repsig_data_out  output  17  output token (output FIFO head).
- repsig_data_out_valid  output  1  output FIFO non-empty and tile_en=1.
- repsig_data_out_ready  input  1  downstream accepts.

Behaviour:
- Token encoding:
  - bit16=0: data token; value in [15:0].
  - bit16=1 and [9:8]=00: stop token, level in [7:0].
  - bit16=1 and [9:8]=01: done token (17'h10100).
- Transfer rule: a transfer occurs on an edge where valid&ready=1.
- Input side: accepted tokens are pushed into the input FIFO.
- Transform, one token per cycle: when the input FIFO is non-empty and the output FIFO is not full, pop the head, transform it, push the result to the output FIFO.
  - data token -> 17'h00001 (R); the input value is discarded.
  - stop token -> {1'b1, in[15:8], (in[7:0]+stop_lvl[7:0]) mod 256}.
  - done token -> 17'h10100 unchanged.
- Latency: a token accepted at edge k is visible on repsig_data_out after edge k+1. Sustained throughput is 1 token/cycle with ready held high.
- FSM states:
  - START: idle; moves to PASS on the first pop.
  - PASS: streaming.
  - DONE: entered when a done token is pushed to the output FIFO; lasts one cycle, then returns to START.
  - Tokens popped while in DONE are processed normally and leave DONE for PASS.
- Full/empty boundaries:
  - FIFO full: ready=0, no accept.
  - Simultaneous push and pop on a full FIFO is allowed only on the output side: push is permitted if a pop occurs the same edge.
  - The input FIFO does not accept when full, even if popping.
  - Pointers wrap modulo FIFO_DEPTH.
- Malformed control tokens (bit16=1, [9:8] in {10,11}): forwarded unchanged.
- rst_n=0, asynchronous:
  - FIFOs emptied; FSM to START; stop_lvl not stored.
  - base_data_in_ready=0, repsig_data_out_valid=0, repsig_data_out=17'h0.
- flush=1 at an edge: same clear as reset. Ready may be 1 in the flush cycle, but nothing is accepted.
- tile_en=0: base_data_in_ready=0, repsig_data_out_valid=0, no pops; contents retained.
- clk_en=0: holds all state.
- Output data when the output FIFO is empty: 17'h0.

Optional Feature:
REPSIG_COUNT_EN:
- Defined:
  - Adds output port rep_count [15:0]: number of R tokens pushed to the output FIFO since the last done token, flush or reset.
  - Cleared to 0 on reset and flush.
  - Cleared to 0 on the edge that pushes a done token; the done token's count is not incremented.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Basic stream, stop_lvl=0, ready=1:
  - In: 00005, 00007, 10000, 00003, 10001, 10100.
  - Out: 00001, 00001, 10000, 00001, 10001, 10100, each 2 cycles after acceptance, 1/cycle.
- Offset: stop_lvl=2.
  - In: 00009, 10000, 10001, 10100.
  - Out: 00001, 10002, 10003, 10100 (done not offset).
- Backpressure: repsig_data_out_ready low for 10 cycles mid-stream.
  - base_data_in_ready drops after 2*FIFO_DEPTH tokens buffered.
  - No loss or duplication; order preserved on release.
- Flush mid-stream after 3 tokens accepted:
  - valid=0 next cycle.
  - A following stream 00001, 10100 yields exactly 00001, 10100.
- tile_en=0 with valid input: ready=0, valid=0, nothing consumed. Re-enabling resumes with buffered tokens intact.
- Async reset pulse mid-stream (not on an edge):
  - Outputs immediately ready=0, valid=0, data=0.
  - Post-reset stream processed cleanly.
  - With REPSIG_COUNT_EN: rep_count=0, increments to 2 after two data tokens, returns to 0 after 10100.

Source files
------------

// File: rtl/repeat_signal_generator.sv
// repeat_signal_generator: turns a coordinate token stream into repeat (R) tokens; stop/done forwarded, stops offset by stop_lvl.
// Define REPSIG_COUNT_EN to add rep_count (R tokens emitted since the last done token, flush or reset).
module repeat_signal_generator #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        flush,
    input  logic        tile_en,
    input  logic [15:0] stop_lvl,
    input  logic [16:0] base_data_in,
    input  logic        base_data_in_valid,
    output logic        base_data_in_ready,
    output logic [16:0] repsig_data_out,
    output logic        repsig_data_out_valid,
    input  logic        repsig_data_out_ready
`ifdef REPSIG_COUNT_EN
    ,
    output logic [15:0] rep_count
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {START, PASS, DONE} state_t;
    state_t        r_state;
    logic [16:0]   r_in_mem  [FIFO_DEPTH];
    logic [16:0]   r_out_mem [FIFO_DEPTH];
    logic [AW-1:0] r_in_wr, r_in_rd, r_out_wr, r_out_rd;
    logic [AW:0]   r_in_cnt, r_out_cnt;
    logic          w_in_full, w_in_empty, w_out_full, w_out_empty;
    logic          w_in_push, w_out_pop, w_xfer;
    logic [16:0]   w_head, w_tok;
    logic          w_head_data, w_head_stop, w_head_done;
    logic          w_unused_stop_lvl;

    assign w_in_full   = r_in_cnt == FULL;
    assign w_in_empty  = r_in_cnt == '0;
    assign w_out_full  = r_out_cnt == FULL;
    assign w_out_empty = r_out_cnt == '0;

    assign base_data_in_ready    = rst_n & tile_en & ~w_in_full;
    assign repsig_data_out_valid = tile_en & ~w_out_empty;
    assign repsig_data_out       = w_out_empty ? 17'h0 : r_out_mem[r_out_rd];

    // The output FIFO may take a new token on a full edge if its head leaves on that same edge.
    assign w_in_push = clk_en & ~flush & base_data_in_valid & base_data_in_ready;
    assign w_out_pop = clk_en & ~flush & repsig_data_out_valid & repsig_data_out_ready;
    assign w_xfer    = clk_en & ~flush & tile_en & ~w_in_empty & (~w_out_full | w_out_pop);

    assign w_head      = r_in_mem[r_in_rd];
    assign w_head_data = ~w_head[16];
    assign w_head_stop = w_head[16] & (w_head[9:8] == 2'b00);
    assign w_head_done = w_head[16] & (w_head[9:8] == 2'b01);
    assign w_tok       = w_head_data ? 17'h00001 :
                         w_head_stop ? {1'b1, w_head[15:8], w_head[7:0] + stop_lvl[7:0]} : w_head;

    assign w_unused_stop_lvl = ^stop_lvl[15:8];

    always_ff @(posedge clk) begin
        if (w_in_push) r_in_mem[r_in_wr] <= base_data_in;
        if (w_xfer) r_out_mem[r_out_wr] <= w_tok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= START;
            r_in_wr   <= '0;
            r_in_rd   <= '0;
            r_in_cnt  <= '0;
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
        end else if (clk_en) begin
            if (flush) begin
                r_state   <= START;
                r_in_wr   <= '0;
                r_in_rd   <= '0;
                r_in_cnt  <= '0;
                r_out_wr  <= '0;
                r_out_rd  <= '0;
                r_out_cnt <= '0;
            end else begin
                r_in_wr   <= r_in_wr + AW'(w_in_push);
                r_in_rd   <= r_in_rd + AW'(w_xfer);
                r_in_cnt  <= r_in_cnt + (AW+1)'(w_in_push) - (AW+1)'(w_xfer);
                r_out_wr  <= r_out_wr + AW'(w_xfer);
                r_out_rd  <= r_out_rd + AW'(w_out_pop);
                r_out_cnt <= r_out_cnt + (AW+1)'(w_xfer) - (AW+1)'(w_out_pop);
                if (w_xfer) r_state <= w_head_done ? DONE : PASS;
                else if (r_state == DONE) r_state <= START;
            end
        end
    end

`ifdef REPSIG_COUNT_EN
    logic [15:0] r_rep_count;
    assign rep_count = r_rep_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rep_count <= '0;
        else if (clk_en) begin
            if (flush || (w_xfer && w_head_done)) r_rep_count <= '0;
            else if (w_xfer && w_head_data && r_rep_count != 16'hFFFF) r_rep_count <= r_rep_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_repeat_signal_generator.sv
// tb_repeat_signal_generator: directed + randomized bench; a token-level scoreboard predicts every output from the accepted inputs.
module tb_repeat_signal_generator;
    localparam int D = 2;
    logic        clk = 0, rst_n = 0, clk_en = 1, flush = 0, tile_en = 1;
    logic [15:0] stop_lvl = 0;
    logic [16:0] base_data_in = 0;
    logic        base_data_in_valid = 0, base_data_in_ready;
    logic [16:0] repsig_data_out;
    logic        repsig_data_out_valid, repsig_data_out_ready = 1;
`ifdef REPSIG_COUNT_EN
    logic [15:0] rep_count;
`endif
    int          checks = 0, failures = 0, cyc = 0, lat = 0, model_cnt = 0;
    logic        chk_lat = 0;
    logic [16:0] exp_q[$], got_log[$];
    int          acc_q[$];
    logic [16:0] basic_in[6]  = '{17'h00005, 17'h00007, 17'h10000, 17'h00003, 17'h10001, 17'h10100};
    logic [16:0] basic_exp[6] = '{17'h00001, 17'h00001, 17'h10000, 17'h00001, 17'h10001, 17'h10100};
    logic [16:0] offs_in[4]   = '{17'h00009, 17'h10000, 17'h10001, 17'h10100};
    logic [16:0] offs_exp[4]  = '{17'h00001, 17'h10002, 17'h10003, 17'h10100};

    repeat_signal_generator #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .stop_lvl(stop_lvl), .base_data_in(base_data_in), .base_data_in_valid(base_data_in_valid),
        .base_data_in_ready(base_data_in_ready), .repsig_data_out(repsig_data_out),
        .repsig_data_out_valid(repsig_data_out_valid), .repsig_data_out_ready(repsig_data_out_ready)
`ifdef REPSIG_COUNT_EN
        , .rep_count(rep_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ref_tok(input logic [16:0] t, input logic [7:0] lvl);
        if (!t[16]) return 17'h00001;
        if (t[9:8] == 2'b00) return {1'b1, t[15:8], t[7:0] + lvl};
        return t;
    endfunction

    function automatic logic [16:0] rnd_tok();
        int k = $urandom_range(0, 9);
        logic [16:0] t = 17'($urandom);
        if (k < 5) t[16] = 1'b0;
        else if (k < 8) begin t[16] = 1'b1; t[9:8] = 2'b00; end
        else if (k == 8) t = 17'h10100;
        else begin t[16] = 1'b1; t[9] = 1'b1; end
        return t;
    endfunction

    function automatic logic [16:0] log_at(input int i);
        return (got_log.size() > i) ? got_log[i] : 17'h1ffff;
    endfunction

    // Handshakes are stable between the falling edge and the next rising edge, so transfers are judged here.
    always @(negedge clk) begin
        if (!rst_n || (flush && clk_en)) begin
            exp_q.delete();
            acc_q.delete();
            model_cnt = 0;
        end else if (clk_en) begin
            if (repsig_data_out_valid && repsig_data_out_ready) begin
                got_log.push_back(repsig_data_out);
                check("out_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("out_tok", repsig_data_out, exp_q.pop_front());
                    lat = cyc - acc_q.pop_front();
                    if (chk_lat) check("latency", lat, 2);
                end
            end
            if (base_data_in_valid && base_data_in_ready) begin
                exp_q.push_back(ref_tok(base_data_in, stop_lvl[7:0]));
                acc_q.push_back(cyc);
                if (!base_data_in[16]) model_cnt = (model_cnt < 65535) ? model_cnt + 1 : model_cnt;
                else if (base_data_in[9:8] == 2'b01) model_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [16:0] t);
        int n = 0;
        logic ok = 0;
        base_data_in = t;
        base_data_in_valid = 1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = base_data_in_ready && clk_en;
            tick();
            n++;
        end
        check("send_done", ok, 1);
    endtask

    task automatic drain();
        int n = 0;
        base_data_in_valid = 0;
        repsig_data_out_ready = 1;
        clk_en = 1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        check("drain_left", exp_q.size(), 0);
        check("drain_idle", repsig_data_out_valid, 0);
`ifdef REPSIG_COUNT_EN
        check("rep_count", rep_count, model_cnt);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int acc;
        #3;
        check("rst_ready", base_data_in_ready, 0);
        check("rst_valid", repsig_data_out_valid, 0);
        check("rst_data", repsig_data_out, 0);
        #20 rst_n = 1;
        tick();
        check("post_rst_ready", base_data_in_ready, 1);
        chk_lat = 1;
        foreach (basic_in[i]) send(basic_in[i]);
        drain();
        chk_lat = 0;
        check("basic_len", got_log.size(), 6);
        foreach (basic_exp[i]) check("basic_out", log_at(i), basic_exp[i]);
        got_log.delete();
        stop_lvl = 16'd2;
        foreach (offs_in[i]) send(offs_in[i]);
        drain();
        check("offs_len", got_log.size(), 4);
        foreach (offs_exp[i]) check("offs_out", log_at(i), offs_exp[i]);
        stop_lvl = 0;
        got_log.delete();
        repsig_data_out_ready = 0;
        acc = 0;
        base_data_in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            base_data_in = (acc == 2) ? 17'h10005 : 17'(acc + 16);
            @(negedge clk);
            if (base_data_in_ready) acc++;
            tick();
        end
        check("bp_accepted", acc, 2 * D);
        check("bp_ready", base_data_in_ready, 0);
        drain();
        check("bp_len", got_log.size(), 2 * D);
        check("bp_o2", log_at(2), 17'h10005);
        repsig_data_out_ready = 0;
        send(17'h00003);
        send(17'h10004);
        send(17'h00006);
        base_data_in_valid = 0;
        flush = 1;
        tick();
        flush = 0;
        check("flush_valid", repsig_data_out_valid, 0);
        check("flush_ready", base_data_in_ready, 1);
        check("flush_data", repsig_data_out, 0);
        got_log.delete();
        repsig_data_out_ready = 1;
        send(17'h00001);
        send(17'h10100);
        drain();
        check("flush_len", got_log.size(), 2);
        check("flush_o0", log_at(0), 17'h00001);
        check("flush_o1", log_at(1), 17'h10100);
        got_log.delete();
        repsig_data_out_ready = 0;
        send(17'h00002);
        send(17'h10003);
        base_data_in = 17'h00004;
        tile_en = 0;
        tick();
        check("tile_ready", base_data_in_ready, 0);
        check("tile_valid", repsig_data_out_valid, 0);
        repsig_data_out_ready = 1;
        repeat (5) tick();
        check("tile_hold_ready", base_data_in_ready, 0);
        check("tile_hold_valid", repsig_data_out_valid, 0);
        base_data_in_valid = 0;
        tile_en = 1;
        drain();
        check("tile_len", got_log.size(), 2);
        check("tile_o1", log_at(1), 17'h10003);
        base_data_in = 17'h00005;
        base_data_in_valid = 1;
        tick();
        base_data_in = 17'h10007;
        tick();
        #2 rst_n = 0;
        #1;
        check("arst_ready", base_data_in_ready, 0);
        check("arst_valid", repsig_data_out_valid, 0);
        check("arst_data", repsig_data_out, 0);
        base_data_in_valid = 0;
        #10 rst_n = 1;
        tick();
        got_log.delete();
        send(17'h00005);
        send(17'h00007);
        drain();
        send(17'h10100);
        drain();
        check("arst_len", got_log.size(), 3);
        check("arst_o2", log_at(2), 17'h10100);
        stop_lvl = 16'($urandom);
        for (int i = 0; i < 800; i++) begin
            base_data_in = rnd_tok();
            base_data_in_valid = 1'($urandom);
            repsig_data_out_ready = $urandom_range(0, 3) != 0;
            clk_en = $urandom_range(0, 7) != 0;
            tick();
        end
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
